// File: rtl/cpu_alu_seq.sv
// Registered ALU with valid/ready handshakes and multi-cycle bit-serial shifts.
// Optional feature: define ALU_SAT_EN to make ADD/SUB saturate instead of wrapping.
module cpu_alu_seq #(
  parameter  int WIDTH   = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;      // 1 = shift right
  logic               cout_q, cout_d;    // last bit shifted out so far
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic [SHAMT_W-1:0] k;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH-1:0]   step_val;
  logic               step_out;
  logic               out_free, accept, is_long_shift;

  assign k             = b[SHAMT_W-1:0];
  assign sum_w         = {1'b0, a} + {1'b0, b};
  assign diff_w        = {1'b0, a} - {1'b0, b};
  assign out_free      = !out_valid_q || out_ready;
  assign in_ready      = rst_n && (state_q == IDLE) && out_free;
  assign accept        = in_valid && in_ready;
  assign is_long_shift = (op[2:1] == 2'b11) && (k != '0);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v);
    return {(r == '0), r[WIDTH-1], c, v};
  endfunction

  // Single-cycle datapath; shifts reach here only with k==0 (pass-through).
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'b000: begin
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
        alu_res = alu_c ? '1 : sum_w[WIDTH-1:0];
`else
        alu_res = sum_w[WIDTH-1:0];
`endif
      end
      3'b001: alu_res = a | b;
      3'b010: alu_res = a ^ b;
      3'b011: alu_res = ~a;
      3'b100: begin
        alu_c   = diff_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
        alu_res = alu_c ? '0 : diff_w[WIDTH-1:0];
`else
        alu_res = diff_w[WIDTH-1:0];
`endif
      end
      3'b101:  alu_res = a & b;
      default: alu_res = a;
    endcase
  end

  // One bit of shift per cycle, zero fill in both directions.
  always_comb begin
    if (dir_q) begin
      step_val = {1'b0, work_q[WIDTH-1:1]};
      step_out = work_q[0];
    end else begin
      step_val = {work_q[WIDTH-2:0], 1'b0};
      step_out = work_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    cout_d      = cout_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_long_shift) begin
            work_d  = a;
            cnt_d   = k;
            dir_d   = op[0];
            cout_d  = 1'b0;
            state_d = SHIFT;
          end else begin
            result_d    = alu_res;
            flags_d     = mk_flags(alu_res, alu_c, alu_v);
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = step_val;
        cout_d = step_out;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          if (out_free) begin
            result_d    = step_val;
            flags_d     = mk_flags(step_val, step_out, 1'b0);
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          result_d    = work_q;
          flags_d     = mk_flags(work_q, cout_q, 1'b0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      cout_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      cout_q      <= cout_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
